// File: rtl/loader_pkg.sv
// Shared definitions for the FIFO loader: default geometry, FSM states and
// the byte-extraction helper used to walk a 64-bit memory word MSB-first.
package loader_pkg;

  localparam int NUM_A  = 8;  // A FIFOs, one matrix row each
  localparam int BYTES  = 8;  // bytes per memory word / entries per FIFO fill
  localparam int B_ADDR = 8;  // word address of the B vector

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  // Byte 0 is the most significant byte of the word, byte 7 the least.
  function automatic logic [7:0] word_byte(input logic [63:0] w, input int idx);
    return w[8*(7-idx) +: 8];
  endfunction

endpackage

// File: rtl/fifo_loader.sv
// Reads one 64-bit word per FIFO over Avalon-MM (rows 0..NUM_A-1 feed the A
// FIFOs, row NUM_A reads B_ADDR into the B FIFO) and shifts each word out a
// byte at a time, most significant byte first.
//
// Read handshake: read/address are held stable for as long as waitrequest is
// high; the request is accepted on the first rising edge where read=1 and
// waitrequest=0. The returned word is taken only while waiting for it
// (readdatavalid anywhere else is ignored). A FIFO write happens on every edge
// where its enable is high; enables are gated by the target's full flag so a
// full FIFO stalls the byte stream without dropping a byte.
module fifo_loader #(
  parameter int NUM_A  = loader_pkg::NUM_A,
  parameter int BYTES  = loader_pkg::BYTES,
  parameter int B_ADDR = loader_pkg::B_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [31:0]          address,
  output logic                 read,
  input  logic                 waitrequest,
  input  logic [63:0]          readdata,
  input  logic                 readdatavalid,
  input  logic [NUM_A-1:0]     fullA,
  input  logic                 fullB,
  output logic [7:0]           datain,
  output logic [NUM_A-1:0]     wrenA,
  output logic                 wrenB,
  output logic                 busy,
  output logic                 done,
  output loader_pkg::state_t   state_dbg
);

  import loader_pkg::*;

  localparam int RW = $clog2(NUM_A + 1);
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t        st, st_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0]   shreg, shreg_n;
  logic [7:0]    datain_n;
  logic [31:0]   address_n;
  logic          target_full;
  logic          last_row;
  logic          last_byte;
  logic          wr_ok;

  // Word address for a row: the B row maps to B_ADDR, A rows map to themselves.
  function automatic logic [31:0] row_addr(input logic [RW-1:0] r);
    return (r == RW'(NUM_A)) ? 32'(B_ADDR) : 32'(r);
  endfunction

  assign state_dbg = st;
  assign last_row  = (row == RW'(NUM_A));
  assign last_byte = (cnt == CW'(BYTES - 1));
  assign wr_ok     = (st == SHIFT) && !target_full;

  // Full flag of the FIFO currently being filled.
  always_comb begin
    target_full = fullB;
    for (int i = 0; i < NUM_A; i++) begin
      if (row == RW'(i)) target_full = fullA[i];
    end
  end

  // Write enables: one-hot by row, dropped combinationally while the target is full.
  always_comb begin
    wrenA = '0;
    for (int i = 0; i < NUM_A; i++) begin
      wrenA[i] = wr_ok && (row == RW'(i));
    end
    wrenB = wr_ok && last_row;
  end

  // Next-state and next-datapath logic for the fill sequence.
  always_comb begin
    st_n      = st;
    row_n     = row;
    cnt_n     = cnt;
    shreg_n   = shreg;
    datain_n  = datain;
    address_n = address;
    case (st)
      IDLE: begin
        if (start) begin
          st_n      = REQ;
          row_n     = '0;
          cnt_n     = '0;
          address_n = row_addr('0);
        end
      end
      REQ: begin
        if (!waitrequest) st_n = WAIT;
      end
      WAIT: begin
        if (readdatavalid) begin
          shreg_n  = readdata;
          cnt_n    = '0;
          datain_n = word_byte(readdata, 0);
          st_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (wr_ok) begin
          if (last_byte) begin
            cnt_n = '0;
            if (last_row) begin
              st_n = DONE;
            end else begin
              row_n     = row + 1'b1;
              address_n = row_addr(row + 1'b1);
              st_n      = REQ;
            end
          end else begin
            cnt_n    = cnt + 1'b1;
            datain_n = word_byte(shreg, int'(cnt) + 1);
          end
        end
      end
      DONE: begin
        st_n = IDLE;
      end
      default: begin
        st_n = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      row     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      datain  <= '0;
      address <= '0;
      read    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      st      <= st_n;
      row     <= row_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      datain  <= datain_n;
      address <= address_n;
      read    <= (st_n == REQ);
      busy    <= (st_n == REQ) || (st_n == WAIT) || (st_n == SHIFT);
      done    <= (st_n == DONE);
    end
  end

endmodule

// File: tb/tb_fifo_loader.sv
// Bench for fifo_loader: an Avalon-MM memory slave with optional stalls and
// random response latency, randomly asserted full flags, and a scoreboard that
// expects every word's bytes, MSB first, to reach the right FIFO in row order.
module tb_fifo_loader;

  localparam int NA = loader_pkg::NUM_A;
  localparam int NB = loader_pkg::BYTES;
  localparam int BA = loader_pkg::B_ADDR;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       address;
  logic              read;
  logic              waitrequest = 1'b0;
  logic [63:0]       readdata = '0;
  logic              readdatavalid = 1'b0;
  logic [NA-1:0]     fullA = '0;
  logic              fullB = 1'b0;
  logic [7:0]        datain;
  logic [NA-1:0]     wrenA;
  logic              wrenB;
  logic              busy;
  logic              done;
  loader_pkg::state_t state_dbg;

  fifo_loader #(.NUM_A(NA), .BYTES(NB), .B_ADDR(BA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .address(address), .read(read), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .fullA(fullA), .fullB(fullB), .datain(datain),
    .wrenA(wrenA), .wrenB(wrenB), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mem [0:63];
  logic [15:0] exp_q [$];   // {target fifo (NA = B), byte}

  bit          rand_stall = 0, rand_full = 0, stray_en = 0, consec_chk = 0;
  bit          stall_arm = 0, f5_arm = 0, late_rdv = 0;
  int          stall_left = 0, f5_left = 0;
  logic [31:0] stall_addr = '0;
  logic [7:0]  f5_data = '0;
  bit          pend = 0, acc_prev = 0, prev_wr = 0;
  int          pend_dly = 0;
  logic [63:0] pend_data = '0;
  logic [31:0] acc_addr = '0;
  int          req_cnt [0:63];
  int          row_wr [0:15];
  int          last_wr_cyc = 0, last_row0_cyc = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- slave, full-flag driver and scoreboard ----------------
  always @(negedge clk) begin
    int tgt;
    logic [15:0] e;
    cyc++;
    // response channel
    readdatavalid = 1'b0;
    if (acc_prev) begin
      acc_prev  = 1'b0;
      pend      = 1'b1;
      pend_dly  = $urandom_range(0, 2);
      pend_data = mem[acc_addr[5:0]];
      req_cnt[acc_addr[5:0]]++;
    end
    if (pend) begin
      if (pend_dly == 0) begin
        readdatavalid = 1'b1;
        readdata      = pend_data;
        pend          = 1'b0;
      end else begin
        pend_dly--;
      end
    end else if (late_rdv || (stray_en && prev_wr && ($urandom_range(0, 3) == 0))) begin
      readdatavalid = 1'b1;
      readdata      = {$urandom, $urandom};
      late_rdv      = 1'b0;
    end
    // request channel
    waitrequest = 1'b0;
    if (stall_arm && read && (address == stall_addr)) begin
      stall_arm  = 1'b0;
      stall_left = 3;
    end
    if (stall_left > 0) begin
      check("stall_read_held", read, 1);
      check("stall_addr_held", address, stall_addr);
      waitrequest = 1'b1;
      stall_left--;
    end else if (read && rand_stall) begin
      waitrequest = ($urandom_range(0, 2) == 0);
    end
    acc_prev = read && !waitrequest;
    acc_addr = address;
    // full flags
    fullA = '0;
    fullB = 1'b0;
    if (rand_full) begin
      for (int i = 0; i < NA; i++) fullA[i] = ($urandom_range(0, 3) == 0);
      fullB = ($urandom_range(0, 3) == 0);
    end
    if (f5_left > 0) fullA[5] = 1'b1;
    // scoreboard
    #1;
    if (f5_left > 0) begin
      check("full5_wren_low", wrenA, 0);
      check("full5_datain_frozen", datain, f5_data);
      f5_left--;
    end
    prev_wr = 1'b0;
    if ((wrenA != '0) || wrenB) begin
      prev_wr = 1'b1;
      check("wren_onehot", $countones({wrenA, wrenB}), 1);
      check("write_while_full", {wrenA & fullA, wrenB & fullB}, 0);
      tgt = NA;
      for (int i = 0; i < NA; i++) if (wrenA[i]) tgt = i;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 16'hdead;
      check("write_target_byte", {8'(tgt), datain}, e);
      if (consec_chk && tgt == 0 && row_wr[0] > 0) check("row0_consecutive", cyc, last_row0_cyc + 1);
      if (tgt == 0) last_row0_cyc = cyc;
      row_wr[tgt]++;
      if (f5_arm && tgt == 5 && row_wr[5] == 2 && exp_q.size() > 0) begin
        f5_arm  = 1'b0;
        f5_left = 4;
        f5_data = exp_q[0][7:0];
      end
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_write", cyc, last_wr_cyc + 1);
      check("busy_low_at_done", busy, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input bit directed);
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    if (directed) begin
      mem[0]  = 64'h0102030405060708;
      mem[BA] = 64'hAABBCCDDEEFF0011;
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r <= NA; r++) begin
      logic [63:0] w;
      w = mem[(r == NA) ? BA : r];
      for (int k = 0; k < NB; k++) exp_q.push_back({8'(r), w[63-8*k -: 8]});
    end
  endtask

  task automatic clear_run();
    for (int i = 0; i < 16; i++) row_wr[i] = 0;
    for (int i = 0; i < 64; i++) req_cnt[i] = 0;
    last_wr_cyc   = -10;
    last_row0_cyc = 0;
  endtask

  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("start_read_latency", read, 1);
    check("start_address", address, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic idle_window(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      check("idle_read", read, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic wait_done(input int budget, input bit poke_start);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
      start = poke_start && busy && ($urandom_range(0, 9) == 0);
    end
    start = 1'b0;
    check("done_within_budget", done_cnt - d0, 1);
    idle_window(6);
    check("exp_queue_drained", exp_q.size(), 0);
    check("done_exactly_once", done_cnt - d0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    check("rst_read", read, 0);
    check("rst_address", address, 0);
    check("rst_datain", datain, 0);
    check("rst_wrenA", wrenA, 0);
    check("rst_wrenB", wrenB, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed word values, row-2 stall, row-5 full stall, no random stress
    fill_mem(1);
    build_expected();
    clear_run();
    consec_chk = 1;
    stall_arm  = 1;
    stall_addr = 32'd2;
    f5_arm     = 1;
    start_seq();
    wait_done(2000, 0);
    check("row2_single_request", req_cnt[2], 1);
    check("row2_stall_seen", stall_arm, 0);
    check("row5_full_seen", f5_arm, 0);
    consec_chk = 0;

    // random stalls, full flags, stray readdatavalid and start pulses while busy
    rand_stall = 1;
    rand_full  = 1;
    stray_en   = 1;
    repeat (3) begin
      fill_mem(0);
      build_expected();
      clear_run();
      start_seq();
      wait_done(4000, 1);
    end
    rand_stall = 0;
    rand_full  = 0;
    stray_en   = 0;

    // reset in the middle of row 3, then a clean restart from row 0
    fill_mem(0);
    build_expected();
    clear_run();
    start_seq();
    n = 0;
    while (row_wr[3] < 2 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reached_row3_shift", row_wr[3] >= 2, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_read", read, 0);
    check("midrst_address", address, 0);
    check("midrst_datain", datain, 0);
    check("midrst_wrenA", wrenA, 0);
    check("midrst_wrenB", wrenB, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    pend     = 1'b0;
    acc_prev = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    late_rdv = 1'b1;
    idle_window(6);
    build_expected();
    clear_run();
    start_seq();
    wait_done(2000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_loader.md
FIFO_LOADER -- requirements
Module: fifo_loader

Interface
REQ-001 SHALL have parameter NUM_A, default 8, meaning number of A FIFOs (one matrix row each).
REQ-002 SHALL have parameter BYTES, default 8, meaning bytes per 64-bit memory word and entries per FIFO fill.
REQ-003 SHALL have parameter B_ADDR, default 8, meaning word address of the B vector.
REQ-004 clk  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a fill sequence.
REQ-007 address  output  32  Avalon-MM read word address.
REQ-008 read  output  1  Avalon-MM read request.
REQ-009 waitrequest  input  1  slave stall; the request is held while high.
REQ-010 readdata  input  64  returned word.
REQ-011 readdatavalid  input  1  readdata qualifier.
REQ-012 fullA  input  NUM_A  per-FIFO full flags, A side.
REQ-013 fullB  input  1  full flag, B FIFO.
REQ-014 datain  output  8  byte presented to the FIFO write ports.
REQ-015 wrenA  output  NUM_A  one-hot write enables, A side.
REQ-016 wrenB  output  1  write enable, B FIFO.
REQ-017 busy  output  1  high from the first cycle after an accepted start until done.
REQ-018 done  output  1  one-cycle pulse when all FIFOs are loaded.

Function
REQ-019 SHALL implement states IDLE, REQ, WAIT, SHIFT, DONE.
REQ-020 IDLE: start=1 -> REQ next cycle; row counter cleared to 0.
REQ-021 REQ: read=1, address=row (rows 0..NUM_A-1 are A FIFOs, row NUM_A uses B_ADDR); read and address held stable while waitrequest=1; waitrequest=0 -> WAIT.
REQ-022 WAIT: read=0; readdatavalid=1 -> latch readdata into the shift register, byte counter=0 -> SHIFT.
REQ-023 SHIFT: datain = latched byte[counter], byte 0 = readdata[63:56], descending to byte 7 = readdata[7:0].
REQ-024 SHIFT: the enable of the target FIFO is high only when that FIFO is not full; a write happens when the enable is high.
REQ-025 SHIFT: target full -> all enables low; datain and counter held (stall, no byte dropped).
REQ-026 SHIFT: write at counter=BYTES-1 -> row+1 -> REQ; at row NUM_A (B) -> DONE.
REQ-027 DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 At most one bit of {wrenA, wrenB} SHALL be high in any cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 readdatavalid outside WAIT SHALL be ignored.
REQ-031 Latency: start at cycle 0 -> read=1 at cycle 1; a row with no stalls takes 8 SHIFT cycles.
REQ-032 Outputs SHALL be registered; no combinational path from readdata to datain.

Reset
REQ-033 rst_n=0 SHALL force IDLE immediately, including mid-sequence, and clear the row counter, byte counter and shift register.
REQ-034 Reset values: read=0, address=0, datain=0, wrenA=0, wrenB=0, busy=0, done=0.
REQ-035 Reset deassertion mid-transfer: a late readdatavalid SHALL be ignored, per REQ-030.

Structure
REQ-036 Shared package loader_pkg SHALL hold the state enum, NUM_A, BYTES and B_ADDR.
REQ-037 There SHALL be no sub-module; the single FSM drives the counters and the shift register.

Verification
REQ-038 Memory word0=0x0102030405060708, no stalls, start -> wrenA[0] high 8 consecutive cycles with datain 01..08.
REQ-039 waitrequest=1 for 3 cycles on row 2 -> read and address=2 held all 3 cycles; exactly one request issued.
REQ-040 fullA[5]=1 for 4 cycles during row-5 SHIFT -> wrenA all 0 and datain frozen for those 4 cycles; all 8 bytes still written.
REQ-041 Full sequence with B word 0xAABBCCDDEEFF0011 -> wrenB writes AA..11; done pulses once 1 cycle later; busy falls with done.
REQ-042 rst_n=0 during row 3 SHIFT -> all outputs 0 at once; next start restarts at row 0, address 0.
REQ-043 start pulsed during busy; stray readdatavalid in SHIFT -> no state, counter or data change.
